tone_sched: RTL
===============

# tone_sched

Scheduler that shares the single square-wave tone generator (`play`) between four note requesters, e.g. game tones, success jingle, game-over melody and UI clicks. Each requester hands over one note (frequency, duration in ms) through a valid/ready handshake. The block arbitrates by fixed priority, times the note on a millisecond timebase derived from `ticks_per_milli`, and drives the generator's `freq` input. It sits between the game FSM and `play`, replacing direct writes to `sound_freq`.

## Interface
- `GAP_MS`, default 10: silence inserted after every naturally completed note, in ms; 0 disables the gap.
- `PREEMPT`, default 1: 1 lets a higher-priority request abort the current note; 0 makes notes non-preemptible.
- `clk`  in  1: system clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `ticks_per_milli`  in  16: clk cycles per ms. Latched at each note accept. A value of 0 is treated as 1.
- `req_valid`  in  4: note request per requester. Index 0 is the highest priority.
- `req_freq`  in  40: packed frequencies in Hz, requester i at [10i+9:10i]. A value of 0 is a rest.
- `req_dur`  in  40: packed durations in ms, requester i at [10i+9:10i].
- `req_ready`  out  4: combinational grant. A note transfers on the clk edge where `req_valid[i] & req_ready[i]`.
- `done`  out  4: one-cycle pulse per requester when its note ends.
- `aborted`  out  1: qualifies `done`. 1 means the note was preempted.
- `busy`  out  1: high in PLAY or GAP.
- `owner`  out  2: index of the requester whose note is playing or last played.
- `freq`  out  10: to `play.freq`. 0 means silent.

## Operation
- States: IDLE, PLAY, GAP.
- Requester rule: keep `req_valid` and its operands stable until `req_ready`. Withdrawing a request before grant is permitted and has no effect.
- Arbitration: the selected requester is the lowest index i with `req_valid[i]`. At most one `req_ready` bit is high at any time.
- IDLE:
  - `req_ready[sel]` = 1 whenever any request is valid.
  - On transfer: latch freq, dur and ticks_per_milli; set `owner`=sel; clear tick and ms counters; go to PLAY.
- PLAY:
  - `freq` holds the latched value.
  - The tick counter counts 0..T-1 and wraps; each wrap decrements the remaining-ms count.
  - When remaining reaches 0: `freq`←0, `done[owner]`←1, `aborted`←0. Then go to GAP, or to IDLE if GAP_MS=0.
- Preemption (only when PREEMPT=1, only in PLAY):
  - Applies when some `req_valid[j]` has j < `owner`. Then `req_ready[j]`=1 and nothing else is granted.
  - On transfer: `done[old owner]`←1, `aborted`←1, the new note is loaded and `owner`=j.
  - Stay in PLAY with no gap.
  - An equal- or lower-priority request never preempts.
- GAP:
  - `freq`=0 and all `req_ready`=0, regardless of PREEMPT.
  - Count GAP_MS ms using the latched T, then go to IDLE.
- Zero-duration note (`req_dur`=0): the note is accepted. Next cycle `done[i]` pulses with `aborted`=0 and `freq` stays 0. The state returns to IDLE with no gap.
- Rest (`req_freq`=0 with dur>0): timed exactly like a tone, with `freq`=0.

## Timing
- Reset values: `freq`=0, `done`=0, `aborted`=0, `busy`=0, `owner`=0, state IDLE, all counters 0. `req_ready`=0 while `rst_n`=0.
- Reset mid-note: `freq` drops to 0 asynchronously and no `done` pulse is issued.
- Accept-to-sound latency: transfer at edge k gives `freq` valid from the cycle after k, for exactly D·T cycles. On edge k+D·T, `freq` returns to 0 and `done` rises; `done` is high for that one cycle.
- The gap lasts GAP_MS·T cycles. The earliest next accept is in the first IDLE cycle after it, so the back-to-back note spacing is GAP_MS·T+1 cycles of `freq`=0.
- In PLAY, a completion and a preempting request can coincide on the final cycle. Preemption wins: the old note reports `aborted`=1 and the new note loads.
- Counter widths: 16-bit tick counter, 10-bit ms counter. Durations up to 1023 ms; there is no wrap inside a note.
- `done` and `aborted` are registered. `req_ready` is combinational from state, `owner` and `req_valid`.

## Test plan
- Single note, T=2: req1 with freq 262, dur 3, transferred at edge k. `freq`=262 for exactly 6 cycles, then 0. `done`=4'b0010 for one cycle with `aborted`=0, then 20 cycles in GAP before IDLE.
- Priority: req2 and req3 valid together in IDLE. Only `req_ready[2]`=1, and req3 is granted on the first IDLE cycle after req2's note and gap.
- Preemption, PREEMPT=1: req3 (784 Hz, 100 ms) is playing and req0 (196 Hz, 5 ms) arrives at ms 40. `done[3]` pulses with `aborted`=1 and `freq`=196 on the next cycle. There is no gap, and `done[0]` follows 5·T cycles later with `aborted`=0. Repeat with PREEMPT=0: req0 waits until after req3's done and the gap.
- Edge cases: dur=0 gives a `done` pulse the cycle after accept, `freq` stays 0 and there is no gap. freq=0 with dur=4 keeps `busy`=1 for 4·T cycles. ticks_per_milli=0 behaves as T=1.
- Reset: assert `rst_n`=0 mid-note. `freq`, `busy` and `req_ready` go to 0 immediately, with no `done` pulse. After release, a fresh request is accepted in IDLE.
- Stability: random valid traffic over 10k cycles. At most one `req_ready` bit is high, exactly one `done` per accepted note, and `owner` matches the granted index.

Source files
------------

// File: rtl/tone_sched.sv
// Fixed-priority scheduler that shares one square-wave tone generator between four note requesters.
// Notes are timed in ms on a latched ticks-per-ms base, with an optional silent gap after each note.
module tone_sched #(
  parameter int unsigned GAP_MS  = 10,
  parameter bit          PREEMPT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] ticks_per_milli,
  input  logic [3:0]  req_valid,
  input  logic [39:0] req_freq,
  input  logic [39:0] req_dur,
  output logic [3:0]  req_ready,
  output logic [3:0]  done,
  output logic        aborted,
  output logic        busy,
  output logic [1:0]  owner,
  output logic [9:0]  freq
);
  localparam logic [9:0] GapMs = 10'(GAP_MS);

  typedef enum logic [1:0] {StIdle, StPlay, StGap} state_e;

  state_e      state_q, state_d;
  logic [9:0]  freq_q, freq_d;
  logic [9:0]  rem_q, rem_d;
  logic [15:0] tick_q, tick_d;
  logic [15:0] tpm_q, tpm_d;
  logic [1:0]  owner_q, owner_d;
  logic [3:0]  done_q, done_d;
  logic        aborted_q, aborted_d;

  logic        any_valid;
  logic [1:0]  sel;
  logic [9:0]  sel_freq, sel_dur;
  logic [15:0] sel_tpm;
  logic [3:0]  grant;
  logic        xfer;
  logic        tick_wrap;

  assign any_valid = |req_valid;

  always_comb begin
    sel = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req_valid[i]) sel = 2'(i);
    end
  end

  assign sel_freq  = req_freq[int'(sel)*10 +: 10];
  assign sel_dur   = req_dur[int'(sel)*10 +: 10];
  assign sel_tpm   = (ticks_per_milli == 16'd0) ? 16'd1 : ticks_per_milli;
  assign tick_wrap = (tick_q == tpm_q - 16'd1);

  // The lowest valid index is the only candidate; in PLAY it must also outrank the owner.
  always_comb begin
    grant = 4'b0000;
    unique case (state_q)
      StIdle:  if (any_valid) grant[sel] = 1'b1;
      StPlay:  if (PREEMPT && any_valid && (sel < owner_q)) grant[sel] = 1'b1;
      default: grant = 4'b0000;
    endcase
  end

  assign req_ready = rst_n ? grant : 4'b0000;
  assign xfer      = |(req_valid & grant);

  always_comb begin
    state_d   = state_q;
    freq_d    = freq_q;
    rem_d     = rem_q;
    tick_d    = tick_q;
    tpm_d     = tpm_q;
    owner_d   = owner_q;
    done_d    = 4'b0000;
    aborted_d = 1'b0;

    if (xfer) begin
      freq_d  = sel_freq;
      rem_d   = sel_dur;
      tpm_d   = sel_tpm;
      tick_d  = 16'd0;
      owner_d = sel;
    end

    unique case (state_q)
      StIdle: begin
        if (xfer) begin
          // A zero-length note completes on its accept edge and never leaves IDLE.
          if (sel_dur == 10'd0) done_d[sel] = 1'b1;
          else                  state_d     = StPlay;
        end
      end
      StPlay: begin
        if (xfer) begin
          done_d[owner_q] = 1'b1;
          aborted_d       = 1'b1;
        end else if (rem_q == 10'd0) begin
          // Zero-length note loaded by a preemption.
          done_d[owner_q] = 1'b1;
          state_d         = StIdle;
        end else if (tick_wrap) begin
          tick_d = 16'd0;
          if (rem_q == 10'd1) begin
            done_d[owner_q] = 1'b1;
            rem_d           = GapMs;
            state_d         = (GapMs == 10'd0) ? StIdle : StGap;
          end else begin
            rem_d = rem_q - 10'd1;
          end
        end else begin
          tick_d = tick_q + 16'd1;
        end
      end
      StGap: begin
        if (tick_wrap) begin
          tick_d = 16'd0;
          rem_d  = rem_q - 10'd1;
          if (rem_q == 10'd1) state_d = StIdle;
        end else begin
          tick_d = tick_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      freq_q    <= 10'd0;
      rem_q     <= 10'd0;
      tick_q    <= 16'd0;
      tpm_q     <= 16'd1;
      owner_q   <= 2'd0;
      done_q    <= 4'b0000;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      freq_q    <= freq_d;
      rem_q     <= rem_d;
      tick_q    <= tick_d;
      tpm_q     <= tpm_d;
      owner_q   <= owner_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  // Gating on state keeps freq silent immediately when reset asserts.
  assign freq    = ((state_q == StPlay) && (rem_q != 10'd0)) ? freq_q : 10'd0;
  assign busy    = (state_q != StIdle);
  assign owner   = owner_q;
  assign done    = done_q;
  assign aborted = aborted_q;

endmodule
